// File: rtl/config_pkg.sv
`default_nettype none
// ============================================================================
// Module      : config_pkg
// Description : Minimal core configuration record (XLEN/PLEN) for the slice.
// Revision    : 1.0 - initial release
// ============================================================================
package config_pkg;

    typedef struct packed {
        int unsigned XLEN;
        int unsigned PLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 64, PLEN: 56};

endpackage
`default_nettype wire

// File: rtl/shadow_reg_restore_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shadow_reg_restore_pkg
// Description : Interrupt shadow frame layout shared by the save and restore units.
// Revision    : 1.0 - initial release
// ============================================================================
package shadow_reg_restore_pkg;

    localparam int unsigned NR_FRAME_WORDS = 18;
    localparam int unsigned NR_GPR_WORDS   = 16;
    localparam logic [4:0]  MEPC_WORD      = 5'd16;
    localparam logic [4:0]  MCAUSE_WORD    = 5'd17;

    // Frame word k (k < 16) holds this architectural GPR.
    localparam logic [4:0] GPR_ORDER [NR_GPR_WORDS] = '{
        5'd1,  5'd5,  5'd6,  5'd7,  5'd10, 5'd11, 5'd12, 5'd13,
        5'd14, 5'd15, 5'd16, 5'd17, 5'd28, 5'd29, 5'd30, 5'd31
    };

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        RESP  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } restore_state_e;

    function automatic logic [4:0] gpr_of_word(input logic [4:0] k);
        return GPR_ORDER[k[3:0]];
    endfunction

endpackage
`default_nettype wire

// File: rtl/shadow_reg_restore_if.sv
`default_nettype none
// ============================================================================
// Module      : shadow_reg_restore_if
// Description : Single-outstanding load channel between restore unit and dcache.
// Revision    : 1.0 - initial release
// ============================================================================
interface shadow_reg_restore_if #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty
);

    logic                      ld_req_o;
    logic                      ld_gnt_i;
    logic [CVA6Cfg.PLEN-1:0]   ld_addr_o;
    logic                      ld_rvalid_i;
    logic [CVA6Cfg.XLEN-1:0]   ld_rdata_i;

    modport master (
        output ld_req_o,
        output ld_addr_o,
        input  ld_gnt_i,
        input  ld_rvalid_i,
        input  ld_rdata_i
    );

    modport slave (
        input  ld_req_o,
        input  ld_addr_o,
        output ld_gnt_i,
        output ld_rvalid_i,
        output ld_rdata_i
    );

endinterface
`default_nettype wire

// File: rtl/shadow_reg_restore.sv
`default_nettype none
// ============================================================================
// Module      : shadow_reg_restore
// Description : Reloads a saved interrupt frame (GPRs, mepc, mcause) on mret.
// Revision    : 1.0 - initial release
// ============================================================================
module shadow_reg_restore
    import shadow_reg_restore_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter int unsigned           NrWords = NR_FRAME_WORDS
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic                    restore_valid_i,
    output logic                    restore_ready_o,
    input  logic [CVA6Cfg.XLEN-1:0] frame_base_i,
    input  logic [4:0]              restore_level_i,
    shadow_reg_restore_if.master    ld_bus,
    output logic                    gpr_we_o,
    output logic [4:0]              gpr_waddr_o,
    output logic [CVA6Cfg.XLEN-1:0] gpr_wdata_o,
    output logic                    csr_we_o,
    output logic                    csr_sel_o,
    output logic [CVA6Cfg.XLEN-1:0] csr_wdata_o,
    output logic                    done_o,
    output logic [CVA6Cfg.XLEN-1:0] next_sp_o,
    output logic [4:0]              restore_level_o
);

    localparam int unsigned XLEN       = CVA6Cfg.XLEN;
    localparam int unsigned PLEN       = CVA6Cfg.PLEN;
    localparam int unsigned WORD_SHIFT = $clog2(XLEN / 8);
    localparam logic [4:0]  LAST_WORD  = 5'(NrWords - 1);

    restore_state_e  state_q, state_d;
    logic [4:0]      k_q, k_d;
    logic [XLEN-1:0] base_q, base_d;
    logic [4:0]      level_q, level_d;
    logic [XLEN-1:0] word_addr;

    assign word_addr = base_q + (XLEN'(k_q) << WORD_SHIFT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            k_q     <= '0;
            base_q  <= '0;
            level_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            base_q  <= base_d;
            level_q <= level_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        k_d              = k_q;
        base_d           = base_q;
        level_d          = level_q;
        restore_ready_o  = 1'b0;
        ld_bus.ld_req_o  = 1'b0;
        ld_bus.ld_addr_o = '0;
        gpr_we_o         = 1'b0;
        gpr_waddr_o      = '0;
        gpr_wdata_o      = '0;
        csr_we_o         = 1'b0;
        csr_sel_o        = 1'b0;
        csr_wdata_o      = '0;
        done_o           = 1'b0;
        next_sp_o        = '0;
        restore_level_o  = '0;

        unique case (state_q)
            IDLE: begin
                restore_ready_o = 1'b1;
                if (restore_valid_i) begin
                    base_d  = frame_base_i;
                    level_d = restore_level_i;
                    k_d     = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                ld_bus.ld_req_o  = 1'b1;
                ld_bus.ld_addr_o = word_addr[PLEN-1:0];
                // A grant that races a flush still owes us an rvalid.
                if (ld_bus.ld_gnt_i) begin
                    state_d = flush_i ? DRAIN : RESP;
                end else if (flush_i) begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                if (ld_bus.ld_rvalid_i) begin
                    if (flush_i) begin
                        state_d = IDLE;
                    end else begin
                        if (k_q < 5'(NR_GPR_WORDS)) begin
                            gpr_we_o    = 1'b1;
                            gpr_waddr_o = gpr_of_word(k_q);
                            gpr_wdata_o = ld_bus.ld_rdata_i;
                        end else if (k_q == MEPC_WORD || k_q == MCAUSE_WORD) begin
                            csr_we_o    = 1'b1;
                            csr_sel_o   = (k_q == MCAUSE_WORD);
                            csr_wdata_o = ld_bus.ld_rdata_i;
                        end
                        if (k_q == LAST_WORD) begin
                            state_d = DONE;
                        end else begin
                            k_d     = k_q + 5'd1;
                            state_d = REQ;
                        end
                    end
                end else if (flush_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (ld_bus.ld_rvalid_i) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                done_o          = 1'b1;
                next_sp_o       = base_q + (XLEN'(NrWords) << WORD_SHIFT);
                restore_level_o = (level_q == 5'd0) ? 5'd0 : level_q - 5'd1;
                state_d         = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_shadow_reg_restore.sv
`default_nettype none
// ============================================================================
// Module      : tb_shadow_reg_restore
// Description : Self-checking bench with a transaction-level frame model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shadow_reg_restore;

    localparam int NW = 18;
    localparam logic [63:0] PMASK = {8'h00, {56{1'b1}}};

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        restore_valid_i = 1'b0;
    logic        restore_ready_o;
    logic [63:0] frame_base_i = '0;
    logic [4:0]  restore_level_i = '0;
    logic        gpr_we_o;
    logic [4:0]  gpr_waddr_o;
    logic [63:0] gpr_wdata_o;
    logic        csr_we_o;
    logic        csr_sel_o;
    logic [63:0] csr_wdata_o;
    logic        done_o;
    logic [63:0] next_sp_o;
    logic [4:0]  restore_level_o;

    shadow_reg_restore_if bus ();

    shadow_reg_restore dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
        .restore_valid_i (restore_valid_i),
        .restore_ready_o (restore_ready_o),
        .frame_base_i    (frame_base_i),
        .restore_level_i (restore_level_i),
        .ld_bus          (bus),
        .gpr_we_o        (gpr_we_o),
        .gpr_waddr_o     (gpr_waddr_o),
        .gpr_wdata_o     (gpr_wdata_o),
        .csr_we_o        (csr_we_o),
        .csr_sel_o       (csr_sel_o),
        .csr_wdata_o     (csr_wdata_o),
        .done_o          (done_o),
        .next_sp_o       (next_sp_o),
        .restore_level_o (restore_level_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] data_of(input logic [63:0] a);
        return {a[31:0] ^ 32'hC0DE_F00D, a[31:0] ^ 32'h1234_5678};
    endfunction

    int gpr_table [16] = '{1, 5, 6, 7, 10, 11, 12, 13, 14, 15, 16, 17, 28, 29, 30, 31};

    // dcache responder
    bit          rand_mode = 0;
    logic [63:0] slow_gnt_addr = '1;
    int          slow_gnt_cycles = 0;
    logic [63:0] slow_rv_addr = '1;
    int          slow_rv_cycles = 0;
    bit          outst = 0;
    logic [63:0] out_addr = '0;
    int          rcnt = 0;
    int          wait_cnt = 0;
    int          gdelay = 0;
    bit          req_seen = 0;
    bit          prev_gnt = 0;
    bit          prev_rv = 0;
    logic [63:0] prev_addr = '0;

    initial begin
        bus.ld_gnt_i    = 1'b0;
        bus.ld_rvalid_i = 1'b0;
        bus.ld_rdata_i  = '0;
        forever begin
            @(posedge clk_i);
            #1;
            if (!rst_ni) begin
                outst = 0; prev_gnt = 0; prev_rv = 0; req_seen = 0;
                bus.ld_gnt_i = 1'b0; bus.ld_rvalid_i = 1'b0;
            end else begin
                if (prev_rv) outst = 0;
                if (prev_gnt) begin
                    outst    = 1;
                    out_addr = prev_addr;
                    rcnt     = (prev_addr == slow_rv_addr) ? slow_rv_cycles :
                               (rand_mode ? int'($urandom_range(0, 3)) : 0);
                end
                bus.ld_rvalid_i = 1'b0;
                bus.ld_rdata_i  = {$urandom, $urandom};
                if (outst) begin
                    if (rcnt == 0) begin
                        bus.ld_rvalid_i = 1'b1;
                        bus.ld_rdata_i  = data_of(out_addr);
                    end else begin
                        rcnt--;
                    end
                end
                bus.ld_gnt_i = 1'b0;
                if (bus.ld_req_o && !outst) begin
                    if (!req_seen) begin
                        req_seen = 1;
                        wait_cnt = 0;
                        gdelay   = (64'(bus.ld_addr_o) == slow_gnt_addr) ? slow_gnt_cycles :
                                   (rand_mode ? int'($urandom_range(0, 3)) : 0);
                    end
                    if (wait_cnt >= gdelay) begin
                        bus.ld_gnt_i = 1'b1;
                        req_seen     = 0;
                    end else begin
                        wait_cnt++;
                    end
                end else begin
                    req_seen = 0;
                end
                prev_gnt  = bus.ld_gnt_i && bus.ld_req_o;
                prev_rv   = bus.ld_rvalid_i;
                prev_addr = 64'(bus.ld_addr_o);
            end
        end
    end

    // Frame-level reference model and per-cycle compare
    bit          m_active = 0;
    bit          m_outst = 0;
    bit          m_drop = 0;
    bit          m_done = 0;
    int          m_k = 0;
    logic [63:0] m_base = '0;
    logic [4:0]  m_lvl = '0;

    logic [63:0] log_addr [$];
    int          log_gpr [$];
    int          log_csr [$];
    int          done_cnt = 0;
    logic [63:0] last_sp = '0;
    logic [4:0]  last_lvl = '0;
    int          cnt_1020 = 0;
    int          x10_writes = 0;
    int          x13_writes = 0;

    initial begin
        bit          exp_req;
        bit          exp_wr;
        logic [63:0] exp_addr;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                check("reset_ready", 64'(restore_ready_o), 64'd1);
                check("reset_outputs_zero", 64'(|{bus.ld_req_o, bus.ld_addr_o, gpr_we_o, gpr_waddr_o,
                      gpr_wdata_o, csr_we_o, csr_sel_o, csr_wdata_o, done_o, next_sp_o, restore_level_o}), 64'd0);
                m_active = 0; m_outst = 0; m_drop = 0; m_done = 0;
            end else begin
                exp_req  = m_active && !m_done && !m_drop && !m_outst;
                exp_addr = (m_base + 64'(m_k) * 64'd8) & PMASK;
                exp_wr   = m_active && !m_done && !m_drop && m_outst && bus.ld_rvalid_i && !flush_i;
                check("ready", 64'(restore_ready_o), 64'(!m_active));
                check("ld_req", 64'(bus.ld_req_o), 64'(exp_req));
                if (exp_req) check("ld_addr", 64'(bus.ld_addr_o), exp_addr);
                check("gpr_we", 64'(gpr_we_o), 64'(exp_wr && m_k < 16));
                check("csr_we", 64'(csr_we_o), 64'(exp_wr && m_k >= 16));
                if (exp_wr && m_k < 16) begin
                    check("gpr_waddr", 64'(gpr_waddr_o), 64'(gpr_table[m_k]));
                    check("gpr_wdata", gpr_wdata_o, data_of(exp_addr));
                end
                if (exp_wr && m_k >= 16) begin
                    check("csr_sel", 64'(csr_sel_o), 64'(m_k == 17));
                    check("csr_wdata", csr_wdata_o, data_of(exp_addr));
                end
                check("done", 64'(done_o), 64'(m_active && m_done));
                if (m_active && m_done) begin
                    check("next_sp", next_sp_o, m_base + 64'(NW * 8));
                    check("level_out", 64'(restore_level_o), 64'((m_lvl == 0) ? 5'd0 : m_lvl - 5'd1));
                end

                if (bus.ld_req_o && bus.ld_gnt_i) log_addr.push_back(64'(bus.ld_addr_o));
                if (bus.ld_req_o && 64'(bus.ld_addr_o) == 64'h8000_1020) cnt_1020++;
                if (gpr_we_o) begin
                    log_gpr.push_back(int'(gpr_waddr_o));
                    if (gpr_waddr_o == 5'd10) x10_writes++;
                    if (gpr_waddr_o == 5'd13) x13_writes++;
                end
                if (csr_we_o) log_csr.push_back(int'(csr_sel_o));
                if (done_o) begin
                    done_cnt++;
                    last_sp  = next_sp_o;
                    last_lvl = restore_level_o;
                end

                if (!m_active) begin
                    if (restore_valid_i) begin
                        m_active = 1; m_base = frame_base_i; m_lvl = restore_level_i;
                        m_k = 0; m_outst = 0; m_drop = 0; m_done = 0;
                    end
                end else if (m_done) begin
                    m_active = 0;
                end else begin
                    if (m_outst && bus.ld_rvalid_i) begin
                        m_outst = 0;
                        if (exp_wr) begin
                            if (m_k == NW - 1) m_done = 1;
                            else m_k++;
                        end
                    end else if (bus.ld_req_o && bus.ld_gnt_i) begin
                        m_outst = 1;
                    end
                    if (flush_i) m_drop = 1;
                    if (m_drop && !m_outst) m_active = 0;
                end
            end
        end
    end

    task automatic clear_logs();
        log_addr.delete(); log_gpr.delete(); log_csr.delete();
        done_cnt = 0; cnt_1020 = 0; x10_writes = 0; x13_writes = 0;
    endtask

    task automatic start_restore(input logic [63:0] base, input logic [4:0] lvl);
        int n = 0;
        @(posedge clk_i); #2;
        while (!restore_ready_o && n < 300) begin
            @(posedge clk_i); #2; n++;
        end
        check("start_ready", 64'(restore_ready_o), 64'd1);
        restore_valid_i = 1'b1; frame_base_i = base; restore_level_i = lvl;
        @(posedge clk_i); #2;
        restore_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input int flush_at, input int busy_at);
        int cyc = 0;
        while (!restore_ready_o && cyc < 500) begin
            flush_i         = (cyc == flush_at);
            restore_valid_i = (cyc == busy_at);
            frame_base_i    = 64'h0000_0000_DEAD_0000;
            restore_level_i = 5'd9;
            @(posedge clk_i); #2; cyc++;
        end
        flush_i = 1'b0; restore_valid_i = 1'b0;
        check("idle_within_bound", 64'(cyc < 500), 64'd1);
    endtask

    initial begin
        int n;
        logic [63:0] rb;
        repeat (3) @(posedge clk_i);
        #3 rst_ni = 1'b1;

        // Zero-wait full frame
        clear_logs();
        start_restore(64'h8000_1000, 5'd2);
        wait_idle(-1, -1);
        check("s1_load_count", 64'(log_addr.size()), 64'd18);
        if (log_addr.size() == 18) begin
            check("s1_first_addr", log_addr[0], 64'h8000_1000);
            check("s1_last_addr", log_addr[17], 64'h8000_1088);
        end
        check("s1_gpr_count", 64'(log_gpr.size()), 64'd16);
        if (log_gpr.size() == 16) begin
            check("s1_gpr0", 64'(log_gpr[0]), 64'd1);
            check("s1_gpr4", 64'(log_gpr[4]), 64'd10);
            check("s1_gpr15", 64'(log_gpr[15]), 64'd31);
        end
        check("s1_csr_count", 64'(log_csr.size()), 64'd2);
        if (log_csr.size() == 2) begin
            check("s1_csr_first_mepc", 64'(log_csr[0]), 64'd0);
            check("s1_csr_second_mcause", 64'(log_csr[1]), 64'd1);
        end
        check("s1_done_count", 64'(done_cnt), 64'd1);
        check("s1_next_sp", last_sp, 64'h8000_1090);
        check("s1_level", 64'(last_lvl), 64'd1);

        // Grant held off three cycles on word 4
        clear_logs();
        slow_gnt_addr = 64'h8000_1020; slow_gnt_cycles = 3;
        start_restore(64'h8000_1000, 5'd2);
        wait_idle(-1, -1);
        slow_gnt_addr = '1;
        check("s2_addr_hold_cycles", 64'(cnt_1020), 64'd4);
        check("s2_x10_writes", 64'(x10_writes), 64'd1);

        // Flush in RESP of word 7, rvalid two cycles later
        clear_logs();
        slow_rv_addr = 64'h8000_1038; slow_rv_cycles = 2;
        start_restore(64'h8000_1000, 5'd2);
        n = 0;
        while (!(outst && out_addr == 64'h8000_1038) && n < 100) begin
            @(posedge clk_i); #2; n++;
        end
        check("s3_reach_word7", 64'(n < 100), 64'd1);
        flush_i = 1'b1;
        @(posedge clk_i); #2;
        flush_i = 1'b0;
        n = 0;
        while (!bus.ld_rvalid_i && n < 10) begin
            @(posedge clk_i); #2; n++;
        end
        check("s3_rvalid_seen", 64'(n < 10), 64'd1);
        @(posedge clk_i); #2;
        check("s3_idle_after_rvalid", 64'(restore_ready_o), 64'd1);
        slow_rv_addr = '1;
        repeat (3) @(posedge clk_i);
        check("s3_no_x13_write", 64'(x13_writes), 64'd0);
        check("s3_no_done", 64'(done_cnt), 64'd0);

        // Request pulsed while busy
        clear_logs();
        start_restore(64'h8000_2000, 5'd5);
        wait_idle(-1, 6);
        check("s4_done_once", 64'(done_cnt), 64'd1);
        check("s4_load_count", 64'(log_addr.size()), 64'd18);
        check("s4_next_sp", last_sp, 64'h8000_2090);
        check("s4_level", 64'(last_lvl), 64'd4);

        // Reset during word 9
        clear_logs();
        rb = 64'h0000_0040_0000_2000;
        start_restore(rb, 5'd3);
        n = 0;
        while (!(bus.ld_req_o && 64'(bus.ld_addr_o) == rb + 64'h48) && n < 100) begin
            @(posedge clk_i); #2; n++;
        end
        check("s5_reach_word9", 64'(n < 100), 64'd1);
        #1 rst_ni = 1'b0;
        #1;
        check("s5_async_ready", 64'(restore_ready_o), 64'd1);
        check("s5_async_req", 64'(bus.ld_req_o), 64'd0);
        repeat (2) @(posedge clk_i);
        #3 rst_ni = 1'b1;
        clear_logs();
        start_restore(64'h0000_0040_0000_3000, 5'd3);
        wait_idle(-1, -1);
        if (log_addr.size() > 0) check("s5_restart_k0", log_addr[0], 64'h0000_0040_0000_3000);
        check("s5_load_count", 64'(log_addr.size()), 64'd18);

        // Level zero saturates
        clear_logs();
        start_restore(64'h8000_1000, 5'd0);
        wait_idle(-1, -1);
        check("s6_done_once", 64'(done_cnt), 64'd1);
        check("s6_level_saturated", 64'(last_lvl), 64'd0);

        // Randomized frames with random dcache latency and occasional flushes
        rand_mode = 1;
        for (int i = 0; i < 12; i++) begin
            int fa;
            fa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 50)) : -1;
            start_restore({$urandom, $urandom} & ~64'h7, 5'($urandom_range(0, 31)));
            wait_idle(fa, -1);
        end
        rand_mode = 0;
        repeat (3) @(posedge clk_i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/shadow_reg_restore.md
SHADOW_REG_RESTORE -- requirements
Module: shadow_reg_restore

Interface
REQ-001 SHALL have parameter CVA6Cfg, default config_pkg::cva6_cfg_empty, the core configuration (XLEN, PLEN used).
REQ-002 SHALL have parameter NrWords, default 18, the number of XLEN words restored per frame.
REQ-003 SHALL have port clk_i, input, 1, the single clock.
REQ-004 SHALL have port rst_ni, input, 1, the asynchronous active-low reset.
REQ-005 SHALL have port flush_i, input, 1, abort the restore in progress.
REQ-006 SHALL have port restore_valid_i, input, 1, restore request from issue on mret.
REQ-007 SHALL have port restore_ready_o, output, 1, unit is idle and accepts a request.
REQ-008 SHALL have port frame_base_i, input, XLEN, frame start address (saved sp).
REQ-009 SHALL have port restore_level_i, input, 5, nesting level being unwound.
REQ-010 SHALL have port ld_req_o, input gnt ld_gnt_i, ld_addr_o (PLEN), ld_rvalid_i, ld_rdata_i (XLEN) — one load channel to the dcache.
REQ-011 SHALL have ports gpr_we_o (1), gpr_waddr_o (5), gpr_wdata_o (XLEN), all outputs, for the register-file write port.
REQ-012 SHALL have ports csr_we_o (1), csr_sel_o (1, 0=mepc 1=mcause), csr_wdata_o (XLEN), all outputs.
REQ-013 SHALL have ports done_o (1, one-cycle pulse), next_sp_o (XLEN), restore_level_o (5), all outputs.

Function
REQ-014 SHALL use FSM states IDLE, REQ, RESP, DRAIN, DONE.
REQ-015 In IDLE, restore_ready_o=1; on restore_valid_i the FSM SHALL latch frame_base_i and restore_level_i, clear word index k, and go to REQ.
REQ-016 In REQ, SHALL assert ld_req_o with ld_addr_o = base + k*(XLEN/8), truncated to PLEN; on ld_gnt_i it SHALL go to RESP.
REQ-017 ld_req_o and ld_addr_o SHALL remain stable until granted; at most one load SHALL be outstanding.
REQ-018 In RESP, on ld_rvalid_i, word k SHALL be written in the same cycle: for k<16, gpr_we_o=1 with gpr_waddr_o = order table [1,5,6,7,10..17,28..31]; for k=16, mepc; for k=17, mcause.
REQ-019 After the write, if k==NrWords-1 the FSM SHALL go to DONE, else k increments and the FSM returns to REQ; the request-to-response turnaround SHALL be 0 extra cycles.
REQ-020 In DONE, SHALL pulse done_o for one cycle with next_sp_o = base + NrWords*(XLEN/8) and restore_level_o = latched level − 1 (saturating at 0), then return to IDLE.
REQ-021 flush_i in REQ before the grant SHALL drop ld_req_o and return to IDLE.
REQ-022 flush_i in RESP, or a flush coinciding with a grant, SHALL go to DRAIN, which consumes the pending rvalid without any write, then returns to IDLE; done_o SHALL NOT pulse.
REQ-023 A flush in the same cycle as an rvalid in RESP SHALL suppress the write and go to IDLE.
REQ-024 restore_valid_i outside IDLE SHALL be ignored.
REQ-025 gpr_we_o, csr_we_o and done_o SHALL NOT be asserted outside RESP and DONE respectively.

Reset
REQ-026 The FSM SHALL reset asynchronously to IDLE.
REQ-027 All outputs SHALL reset to 0, except restore_ready_o, which resets to 1.
REQ-028 Reset mid-restore SHALL abandon the frame, with no further writes.

Structure
REQ-029 The shared package SHALL hold the frame word count, the order table (16-entry GPR index array), and the CSR word indices, so the save unit and the restore unit share one layout.
REQ-030 The block SHALL be a single module with one FSM and no sub-module; the order-table lookup SHALL be a package function.

Verification (XLEN=64)
REQ-031 The bench SHALL cover: base 0x8000_1000, level 2, zero-wait dcache -> 18 loads at 0x8000_1000..0x8000_1088 step 8, GPR writes x1,x5..x31 in order, mepc then mcause, done_o with next_sp_o=0x8000_1090 and level_o=1.
REQ-032 The bench SHALL cover: grant delayed 3 cycles on word 4 -> ld_addr_o held at 0x8000_1020 for all 4 cycles, and a single write to x10.
REQ-033 The bench SHALL cover: flush_i in RESP of word 7, rvalid 2 cycles later -> no write to x13, FSM in IDLE one cycle after the rvalid, no done_o.
REQ-034 The bench SHALL cover: restore_valid_i pulsed during a busy restore -> ignored, and the frame completes once.
REQ-035 The bench SHALL cover: rst_ni asserted during word 9 -> all outputs 0, restore_ready_o=1, and a subsequent request restarts at k=0.
REQ-036 The bench SHALL cover: restore_level_i=0 -> restore_level_o=0, saturated.
